fetch_stage: RTL and testbench

Instruction fetch stage of the RISC-V pipeline. Holds the program counter and drives the instruction memory address. Captures the returned instruction word into the IF/ID pipeline register consumed by decode. Handles sequential advance, branch/jump redirect from execute, hazard-unit stalls and pipeline flushes.

---
 rtl/riscv_structures.sv | 14 +
 rtl/if_id_reg.sv | 37 +++
 rtl/fetch_stage.sv | 66 ++++++
 tb/tb_fetch_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_structures.sv
// rtl/riscv_structures.sv - shared pipeline register types and constants
package riscv_structures;

  // Canonical bubble: addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with bubble/hold/load priority
module if_id_reg
  import riscv_structures::if_id_t;
#(
  parameter logic [31:0] NOP_INSTR = riscv_structures::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        bubble,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instr,
  output if_id_t      q
);

  if_id_t empty_entry;
  if_id_t load_entry;

  always_comb begin
    empty_entry          = '0;
    empty_entry.instr    = NOP_INSTR;
    load_entry.valid     = 1'b1;
    load_entry.pc        = fetch_pc;
    load_entry.pc_plus4  = fetch_pc + 32'd4;
    load_entry.instr     = fetch_instr;
  end

  // Bubble beats stall so a redirect/flush never leaves a wrong-path word held.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      q <= empty_entry;
    end else if (!stall) begin
      q <= load_entry;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, next-PC selection and IF/ID capture
module fetch_stage
  import riscv_structures::if_id_t;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_structures::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instr
);

  logic [31:0] pc_q;
  logic [31:0] next_pc;
  if_id_t      if_id_q;
  logic        unused_target_lsbs;

  assign unused_target_lsbs = ^redirect_target[1:0];

  // Redirect overrides stall: the resolved branch must not be lost.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (redirect_valid) begin
      next_pc = {redirect_target[31:2], 2'b00};
    end else if (stall) begin
      next_pc = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= next_pc;
    end
  end

  assign imem_addr = pc_q;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .bubble      (flush | redirect_valid),
    .fetch_pc    (pc_q),
    .fetch_instr (imem_rdata),
    .q           (if_id_q)
  );

  assign id_valid    = if_id_q.valid;
  assign id_pc       = if_id_q.pc;
  assign id_pc_plus4 = if_id_q.pc_plus4;
  assign id_instr    = if_id_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4),
    .id_instr        (id_instr)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h0001_0001) ^ 32'h5A00_0007;
  endfunction

  always_comb imem_rdata = mem(imem_addr);

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] target;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic addv(input logic r, input logic s, input logic f, input logic rv, input logic [31:0] t,
                      input logic [31:0] ea, input logic ev, input logic [31:0] ep, input logic [31:0] ep4,
                      input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.redir = rv; v.target = t;
    v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_pc4 = ep4; v.e_instr = ei;
    vecs.push_back(v);
  endtask

  task automatic bubble_row(input logic r, input logic s, input logic f, input logic rv,
                            input logic [31:0] t, input logic [31:0] ea);
    addv(r, s, f, rv, t, ea, 1'b0, 32'h0, 32'h0, NOP);
  endtask

  task automatic fetch_row(input logic [31:0] ea, input logic [31:0] ep);
    addv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, ea, 1'b1, ep, ep + 32'd4, mem(ep));
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic rv, input logic [31:0] t);
    @(negedge clk);
    rst = r; stall = s; flush = f; redirect_valid = rv; redirect_target = t;
    @(posedge clk);
    #1;
  endtask

  // Reference model state: architectural PC and IF/ID contents
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_idpc, m_idpc4, m_instr;

  task automatic model_step(input logic r, input logic s, input logic f, input logic rv, input logic [31:0] t);
    logic [31:0] fetched;
    fetched = mem(m_pc);
    if (r) begin
      m_valid = 0; m_idpc = 0; m_idpc4 = 0; m_instr = NOP;
    end else if (f || rv) begin
      m_valid = 0; m_idpc = 0; m_idpc4 = 0; m_instr = NOP;
    end else if (!s) begin
      m_valid = 1; m_idpc = m_pc; m_idpc4 = m_pc + 4; m_instr = fetched;
    end
    if (r) m_pc = 32'h0;
    else if (rv) m_pc = t & 32'hFFFF_FFFC;
    else if (!s) m_pc = m_pc + 4;
  endtask

  initial begin
    // Directed table: inputs for one edge, expected outputs just after it
    bubble_row(1, 0, 0, 0, 0, 32'h0);
    fetch_row(32'h4, 32'h0);
    fetch_row(32'h8, 32'h4);
    addv(0, 1, 0, 0, 0, 32'h8, 1, 32'h4, 32'h8, 32'h0010_0113);
    addv(0, 1, 0, 0, 0, 32'h8, 1, 32'h4, 32'h8, 32'h0010_0113);
    addv(0, 1, 0, 0, 0, 32'h8, 1, 32'h4, 32'h8, 32'h0010_0113);
    fetch_row(32'hC, 32'h8);
    fetch_row(32'h10, 32'hC);
    bubble_row(0, 0, 0, 1, 32'h40, 32'h40);
    fetch_row(32'h44, 32'h40);
    bubble_row(0, 1, 0, 1, 32'h43, 32'h40);
    fetch_row(32'h44, 32'h40);
    bubble_row(0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    fetch_row(32'h0, 32'hFFFF_FFFC);
    fetch_row(32'h4, 32'h0);
    bubble_row(0, 1, 1, 0, 0, 32'h4);
    bubble_row(0, 0, 1, 0, 0, 32'h8);
    fetch_row(32'hC, 32'h8);
    bubble_row(0, 0, 0, 1, 32'h20, 32'h20);
    bubble_row(0, 1, 0, 0, 0, 32'h20);
    bubble_row(1, 1, 0, 0, 0, 32'h0);
    bubble_row(1, 0, 0, 1, 32'h80, 32'h0);
    fetch_row(32'h4, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].redir, vecs[i].target);
      check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d id_valid", i), {31'h0, id_valid}, {31'h0, vecs[i].e_valid});
      check($sformatf("v%0d id_pc", i), id_pc, vecs[i].e_pc);
      check($sformatf("v%0d id_pc_plus4", i), id_pc_plus4, vecs[i].e_pc4);
      check($sformatf("v%0d id_instr", i), id_instr, vecs[i].e_instr);
    end

    // Hand sequence: redirect target appears on the second edge, unstalled
    m_pc = 32'h4; m_valid = 1; m_idpc = 0; m_idpc4 = 4; m_instr = mem(0);
    drive(0, 0, 0, 1, 32'h100);
    check("redir_bubble_valid", {31'h0, id_valid}, 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    check("redir_target_pc", id_pc, 32'h100);
    check("redir_target_instr", id_instr, mem(32'h100));
    m_pc = 32'h104; m_valid = 1; m_idpc = 32'h100; m_idpc4 = 32'h104; m_instr = mem(32'h100);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      logic r, s, f, rv;
      logic [31:0] t;
      r  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 9) == 0);
      rv = ($urandom_range(0, 6) == 0);
      t  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC | $urandom_range(0, 3) : $urandom;
      model_step(r, s, f, rv, t);
      drive(r, s, f, rv, t);
      check($sformatf("rnd%0d imem_addr", c), imem_addr, m_pc);
      check($sformatf("rnd%0d id_valid", c), {31'h0, id_valid}, {31'h0, m_valid});
      check($sformatf("rnd%0d id_pc", c), id_pc, m_idpc);
      check($sformatf("rnd%0d id_pc_plus4", c), id_pc_plus4, m_idpc4);
      check($sformatf("rnd%0d id_instr", c), id_instr, m_instr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
